// File: rtl/csr_pkg.sv
// Shared Zicsr definitions: funct3 codes, sequencer state encoding and CSR addresses.
// Used by the access sequencer, the CSR file and the trap path. No logic or latency here.
package csr_pkg;

    localparam int MXLEN_DEFAULT = 32;

    localparam logic [2:0] CSRRW  = 3'b001;
    localparam logic [2:0] CSRRS  = 3'b010;
    localparam logic [2:0] CSRRC  = 3'b011;
    localparam logic [2:0] CSRRWI = 3'b101;
    localparam logic [2:0] CSRRSI = 3'b110;
    localparam logic [2:0] CSRRCI = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } csr_state_e;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    // funct3 values 000 and 100 are not Zicsr encodings.
    function automatic logic funct3_bad(input logic [2:0] f3);
        return f3[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/csr_alu.sv
// CSR read-modify-write datapath: new value from old value and source operand.
// Purely combinational (zero latency), no flow control.
module csr_alu
    import csr_pkg::*;
#(
    parameter int MXLEN = MXLEN_DEFAULT
) (
    input  logic [2:0]       funct3_i,
    input  logic [MXLEN-1:0] old_i,
    input  logic [MXLEN-1:0] src_i,
    output logic [MXLEN-1:0] new_o
);

    always_comb begin
        new_o = old_i;
        case (funct3_i)
            CSRRW, CSRRWI: new_o = src_i;
            CSRRS, CSRRSI: new_o = old_i | src_i;
            CSRRC, CSRRCI: new_o = old_i & ~src_i;
            default:       new_o = old_i;
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// Zicsr sequencer: one instruction at a time, IDLE->READ->WRITE->RESP, response 3 cycles after accept.
// Response holds while rsp_ready is low; no new request and no CSR access until it is taken.
module csr_access_unit
    import csr_pkg::*;
#(
    parameter int MXLEN = MXLEN_DEFAULT
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_funct3,
    input  logic [11:0]      req_csr_addr,
    input  logic [4:0]       req_rs1_field,
    input  logic [MXLEN-1:0] req_rs1_data,
    input  logic [4:0]       req_rd,
    output logic [11:0]      csr_addr,
    output logic             csr_rd_en,
    input  logic [MXLEN-1:0] csr_rdata,
    input  logic             csr_addr_illegal,
    output logic             csr_wr_en,
    output logic [MXLEN-1:0] csr_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [4:0]       rsp_rd,
    output logic [MXLEN-1:0] rsp_rd_data,
    output logic             rsp_rd_we,
    output logic             rsp_illegal
);

    csr_state_e       state_q;
    logic [2:0]       funct3_q;
    logic [4:0]       rd_q;
    logic [MXLEN-1:0] src_q;
    logic [MXLEN-1:0] old_q;
    logic             do_write_q;
    logic             bad_f3_q;
    logic             illegal_q;

    logic             req_ready_q, csr_rd_en_q, csr_wr_en_q;
    logic [11:0]      csr_addr_q;
    logic [MXLEN-1:0] csr_wdata_q, rsp_rd_data_q;
    logic             rsp_valid_q, rsp_rd_we_q, rsp_illegal_q;
    logic [4:0]       rsp_rd_q;

    logic             bad_f3_d, is_rw_d, do_write_d, do_read_d, illegal_d;
    logic [MXLEN-1:0] src_d, new_d;

    assign bad_f3_d   = funct3_bad(req_funct3);
    assign is_rw_d    = req_funct3[1:0] == 2'b01;
    assign src_d      = req_funct3[2] ? {{(MXLEN-5){1'b0}}, req_rs1_field} : req_rs1_data;
    assign do_write_d = is_rw_d || (req_rs1_field != 5'd0);
    assign do_read_d  = !(is_rw_d && (req_rd == 5'd0));
    // Only meaningful while in READ, the one state where csr_addr_illegal is trusted.
    assign illegal_d  = bad_f3_q || csr_addr_illegal || (do_write_q && (csr_addr_q[11:10] == 2'b11));

    csr_alu #(.MXLEN(MXLEN)) u_alu (
        .funct3_i (funct3_q),
        .old_i    (csr_rdata),
        .src_i    (src_q),
        .new_o    (new_d)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            funct3_q      <= 3'd0;
            rd_q          <= 5'd0;
            src_q         <= '0;
            old_q         <= '0;
            do_write_q    <= 1'b0;
            bad_f3_q      <= 1'b0;
            illegal_q     <= 1'b0;
            req_ready_q   <= 1'b1;
            csr_rd_en_q   <= 1'b0;
            csr_wr_en_q   <= 1'b0;
            csr_addr_q    <= 12'd0;
            csr_wdata_q   <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rd_q      <= 5'd0;
            rsp_rd_data_q <= '0;
            rsp_rd_we_q   <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        funct3_q    <= req_funct3;
                        rd_q        <= req_rd;
                        src_q       <= src_d;
                        do_write_q  <= do_write_d;
                        bad_f3_q    <= bad_f3_d;
                        csr_addr_q  <= req_csr_addr;
                        csr_rd_en_q <= do_read_d && !bad_f3_d;
                        req_ready_q <= 1'b0;
                        state_q     <= READ;
                    end
                end
                READ: begin
                    old_q       <= csr_rdata;
                    illegal_q   <= illegal_d;
                    csr_rd_en_q <= 1'b0;
                    csr_wr_en_q <= do_write_q && !illegal_d;
                    csr_wdata_q <= (do_write_q && !illegal_d) ? new_d : '0;
                    state_q     <= WRITE;
                end
                WRITE: begin
                    csr_wr_en_q   <= 1'b0;
                    csr_wdata_q   <= '0;
                    rsp_valid_q   <= 1'b1;
                    rsp_rd_q      <= rd_q;
                    rsp_rd_data_q <= illegal_q ? '0 : old_q;
                    rsp_rd_we_q   <= (rd_q != 5'd0) && !illegal_q;
                    rsp_illegal_q <= illegal_q;
                    state_q       <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q   <= 1'b0;
                        rsp_rd_q      <= 5'd0;
                        rsp_rd_data_q <= '0;
                        rsp_rd_we_q   <= 1'b0;
                        rsp_illegal_q <= 1'b0;
                        csr_addr_q    <= 12'd0;
                        req_ready_q   <= 1'b1;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign csr_addr    = csr_addr_q;
    assign csr_rd_en   = csr_rd_en_q;
    assign csr_wr_en   = csr_wr_en_q;
    assign csr_wdata   = csr_wdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rd      = rsp_rd_q;
    assign rsp_rd_data = rsp_rd_data_q;
    assign rsp_rd_we   = rsp_rd_we_q;
    assign rsp_illegal = rsp_illegal_q;

endmodule
